// File: rtl/st_channel_adapter_pipe.sv
// Avalon-ST channel adapter: filters packets against a channel window, re-bases channels, registered skid output.
// Optional drop statistics are compiled in when ST_CHAN_DROP_STATS_EN is defined.
module st_channel_adapter_pipe #(
  parameter int DATA_W        = 8,
  parameter int IN_CHANNEL_W  = 8,
  parameter int OUT_CHANNEL_W = 1,
  parameter int CHANNEL_BASE  = 0,
  parameter int MAX_CHANNEL   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
`ifdef ST_CHAN_DROP_STATS_EN
  ,
  input  logic                     stats_clear,
  output logic [15:0]              drop_pkt_count,
  output logic [15:0]              orphan_count,
  output logic                     drop_sticky
`endif
);

  localparam int BEAT_W = DATA_W + OUT_CHANNEL_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic              accept;
  logic              lo_ok;
  logic              hi_ok;
  logic              in_window;
  logic              forward;
  logic              main_free;
  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] main_reg;
  logic [BEAT_W-1:0] skid_reg;
  logic              main_valid_reg;
  logic              skid_valid_reg;
  logic              in_ready_reg;

  assign accept = in_valid & in_ready_reg;

  // Bounds that cover the whole channel range collapse to constants.
  generate
    if (CHANNEL_BASE == 0) begin : g_lo_open
      assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign lo_ok = (in_channel >= IN_CHANNEL_W'(CHANNEL_BASE));
    end
    if (MAX_CHANNEL >= (1 << IN_CHANNEL_W) - 1) begin : g_hi_open
      assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign hi_ok = (in_channel <= IN_CHANNEL_W'(MAX_CHANNEL));
    end
  endgenerate

  assign in_window = lo_ok & hi_ok;

  assign beat_in = {in_startofpacket, in_endofpacket,
                    OUT_CHANNEL_W'(in_channel - IN_CHANNEL_W'(CHANNEL_BASE)),
                    in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pass/drop is decided on SOP and held until EOP; a fresh SOP always re-decides.
  always_comb begin
    state_next = state_reg;
    forward    = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        if (in_window) begin
          forward    = 1'b1;
          state_next = in_endofpacket ? IDLE : PASS;
        end else begin
          state_next = in_endofpacket ? IDLE : DROP;
        end
      end else begin
        case (state_reg)
          PASS: begin
            forward = 1'b1;
            if (in_endofpacket) state_next = IDLE;
          end
          DROP: begin
            if (in_endofpacket) state_next = IDLE;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
    end
  end

  assign main_free = ~main_valid_reg | out_ready;

  // in_ready only ever depends on registered skid occupancy, never on out_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      if (skid_valid_reg) begin
        if (out_ready) begin
          main_reg       <= skid_reg;
          skid_valid_reg <= 1'b0;
        end
      end else if (forward) begin
        if (main_free) begin
          main_reg       <= beat_in;
          main_valid_reg <= 1'b1;
        end else begin
          skid_reg       <= beat_in;
          skid_valid_reg <= 1'b1;
        end
      end else if (out_ready) begin
        main_valid_reg <= 1'b0;
      end
      in_ready_reg <= ~(skid_valid_reg ? ~out_ready : (forward & ~main_free));
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign {out_startofpacket, out_endofpacket, out_channel, out_data} = main_reg;

`ifdef ST_CHAN_DROP_STATS_EN
  logic        drop_start;
  logic        orphan;
  logic [15:0] drop_pkt_count_reg;
  logic [15:0] orphan_count_reg;
  logic        drop_sticky_reg;

  assign drop_start = accept & in_startofpacket & ~in_window;
  assign orphan     = accept & ~in_startofpacket & (state_reg == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_pkt_count_reg <= '0;
      orphan_count_reg   <= '0;
      drop_sticky_reg    <= 1'b0;
    end else if (stats_clear) begin
      drop_pkt_count_reg <= '0;
      orphan_count_reg   <= '0;
      drop_sticky_reg    <= 1'b0;
    end else begin
      if (drop_start && drop_pkt_count_reg != 16'hFFFF)
        drop_pkt_count_reg <= drop_pkt_count_reg + 16'd1;
      if (orphan && orphan_count_reg != 16'hFFFF)
        orphan_count_reg <= orphan_count_reg + 16'd1;
      if (accept && !forward)
        drop_sticky_reg <= 1'b1;
    end
  end

  assign drop_pkt_count = drop_pkt_count_reg;
  assign orphan_count   = orphan_count_reg;
  assign drop_sticky    = drop_sticky_reg;
`endif

endmodule

// File: tb/tb_st_channel_adapter_pipe.sv
// Scoreboard bench for st_channel_adapter_pipe: dut0 uses default window [0,0], dut1 uses window [4,5].
module tb_st_channel_adapter_pipe;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       ch;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_ready [2];
  logic       in_valid [2];
  logic [7:0] in_data [2];
  logic [7:0] in_channel [2];
  logic       in_sop [2];
  logic       in_eop [2];
  logic       out_ready [2];
  logic       out_valid [2];
  logic [7:0] out_data [2];
  logic       out_channel [2];
  logic       out_sop [2];
  logic       out_eop [2];
`ifdef ST_CHAN_DROP_STATS_EN
  logic        stats_clear [2];
  logic [15:0] drop_pkt_count [2];
  logic [15:0] orphan_count [2];
  logic        drop_sticky [2];
`endif

  beat_t exp_q0[$];
  beat_t exp_q1[$];
  beat_t held [2];
  logic  held_v [2];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  st_channel_adapter_pipe #(.DATA_W(8), .IN_CHANNEL_W(8), .OUT_CHANNEL_W(1),
                            .CHANNEL_BASE(0), .MAX_CHANNEL(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_ready(in_ready[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_channel(in_channel[0]), .in_startofpacket(in_sop[0]), .in_endofpacket(in_eop[0]),
    .out_ready(out_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_channel(out_channel[0]), .out_startofpacket(out_sop[0]), .out_endofpacket(out_eop[0])
`ifdef ST_CHAN_DROP_STATS_EN
    , .stats_clear(stats_clear[0]), .drop_pkt_count(drop_pkt_count[0]),
    .orphan_count(orphan_count[0]), .drop_sticky(drop_sticky[0])
`endif
  );

  st_channel_adapter_pipe #(.DATA_W(8), .IN_CHANNEL_W(8), .OUT_CHANNEL_W(1),
                            .CHANNEL_BASE(4), .MAX_CHANNEL(5)) dut1 (
    .clk(clk), .reset(reset),
    .in_ready(in_ready[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_channel(in_channel[1]), .in_startofpacket(in_sop[1]), .in_endofpacket(in_eop[1]),
    .out_ready(out_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_channel(out_channel[1]), .out_startofpacket(out_sop[1]), .out_endofpacket(out_eop[1])
`ifdef ST_CHAN_DROP_STATS_EN
    , .stats_clear(stats_clear[1]), .drop_pkt_count(drop_pkt_count[1]),
    .orphan_count(orphan_count[1]), .drop_sticky(drop_sticky[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one beat on dut d, holding it until accepted; expected output is queued at acceptance.
  task automatic send(input int d, input logic [7:0] data, input logic [7:0] ch,
                      input logic sop, input logic eop, input logic exp_fwd);
    logic       acc;
    int         budget;
    beat_t      b;
    logic [7:0] rebased;
    in_valid[d]   = 1'b1;
    in_data[d]    = data;
    in_channel[d] = ch;
    in_sop[d]     = sop;
    in_eop[d]     = eop;
    acc    = 1'b0;
    budget = 0;
    while (!acc && budget < 100) begin
      acc = in_ready[d];
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid[d] = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'(acc), 32'(1));
    end else begin
      $display("dut%0d in  data=%h ch=%0d sop=%0d eop=%0d fwd=%0d", d, data, ch, sop, eop, exp_fwd);
      if (exp_fwd) begin
        rebased = ch - ((d == 1) ? 8'd4 : 8'd0);
        b.sop  = sop;
        b.eop  = eop;
        b.ch   = rebased[0];
        b.data = data;
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
      end
    end
  endtask

  task automatic monitor_step(input int d);
    beat_t cur;
    beat_t e;
    int    qsize;
    cur = {out_sop[d], out_eop[d], out_channel[d], out_data[d]};
    if (reset) begin
      held_v[d] = 1'b0;
      return;
    end
    if (held_v[d]) begin
      check("stall_valid", 32'(out_valid[d]), 32'(1));
      check("stall_beat", 32'(cur), 32'(held[d]));
    end
    if (out_valid[d] && out_ready[d]) begin
      held_v[d] = 1'b0;
      qsize = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qsize == 0) begin
        check("unexpected_beat", 32'(cur), 32'(0));
      end else begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        $display("dut%0d out data=%h ch=%0d sop=%0d eop=%0d", d, cur.data, cur.ch, cur.sop, cur.eop);
        check("out_data", 32'(cur.data), 32'(e.data));
        check("out_channel", 32'(cur.ch), 32'(e.ch));
        check("out_sop", 32'(cur.sop), 32'(e.sop));
        check("out_eop", 32'(cur.eop), 32'(e.eop));
      end
    end else if (out_valid[d]) begin
      held_v[d] = 1'b1;
      held[d]   = cur;
    end else begin
      held_v[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitor_step(d);
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_channel[d] = '0;
      in_sop[d] = 1'b0; in_eop[d] = 1'b0; out_ready[d] = 1'b1; held_v[d] = 1'b0;
`ifdef ST_CHAN_DROP_STATS_EN
      stats_clear[d] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready[0]), 32'(0));
    check("reset_out_valid", 32'(out_valid[0]), 32'(0));
    check("reset_out_data", 32'(out_data[0]), 32'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(in_ready[0]), 32'(1));

    // 4-beat packet on channel 0, first output one clock after first accept
    send(0, 8'h11, 8'd0, 1'b1, 1'b0, 1'b1);
    check("latency_valid", 32'(out_valid[0]), 32'(1));
    check("latency_data", 32'(out_data[0]), 32'h11);
    send(0, 8'h12, 8'd0, 1'b0, 1'b0, 1'b1);
    send(0, 8'h13, 8'd0, 1'b0, 1'b0, 1'b1);
    send(0, 8'h14, 8'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Out-of-window packet is dropped whole, following in-window packet passes
    send(0, 8'h21, 8'd2, 1'b1, 1'b0, 1'b0);
    check("drop_no_output", 32'(out_valid[0]), 32'(0));
    send(0, 8'h22, 8'd0, 1'b0, 1'b0, 1'b0);
    send(0, 8'h23, 8'd0, 1'b0, 1'b1, 1'b0);
    send(0, 8'h31, 8'd0, 1'b1, 1'b0, 1'b1);
    send(0, 8'h32, 8'd1, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
`ifdef ST_CHAN_DROP_STATS_EN
    check("drop_pkt_count", 32'(drop_pkt_count[0]), 32'(1));
    check("drop_sticky", 32'(drop_sticky[0]), 32'(1));
`endif

    // Window [4,5] with re-basing
    send(1, 8'h43, 8'd3, 1'b1, 1'b1, 1'b0);
    send(1, 8'h44, 8'd4, 1'b1, 1'b1, 1'b1);
    send(1, 8'h45, 8'd5, 1'b1, 1'b1, 1'b1);
    send(1, 8'h46, 8'd6, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
`ifdef ST_CHAN_DROP_STATS_EN
    check("dut1_drop_pkt_count", 32'(drop_pkt_count[1]), 32'(2));
`endif

    // Backpressure: out_ready toggles, then held low until the skid fills
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, 8'h50 + 8'(i), 8'd0, (i == 0), (i == 7), 1'b1);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          out_ready[0] = ((i % 2) == 0);
          @(posedge clk);
          #1;
        end
        out_ready[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_low", 32'(in_ready[0]), 32'(0));
        check("bp_out_valid_high", 32'(out_valid[0]), 32'(1));
        out_ready[0] = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Orphan, missing EOP, then an orphan again to show the FSM is back in IDLE
    send(0, 8'h60, 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef ST_CHAN_DROP_STATS_EN
    check("orphan_count", 32'(orphan_count[0]), 32'(1));
`endif
    send(0, 8'h61, 8'd0, 1'b1, 1'b0, 1'b1);
    send(0, 8'h62, 8'd0, 1'b1, 1'b1, 1'b1);
    send(0, 8'h63, 8'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
`ifdef ST_CHAN_DROP_STATS_EN
    check("orphan_count_2", 32'(orphan_count[0]), 32'(2));
    stats_clear[0] = 1'b1;
    @(posedge clk);
    #1;
    stats_clear[0] = 1'b0;
    check("clear_drop_pkt", 32'(drop_pkt_count[0]), 32'(0));
    check("clear_orphan", 32'(orphan_count[0]), 32'(0));
    check("clear_sticky", 32'(drop_sticky[0]), 32'(0));
`endif

    // Asynchronous reset in the middle of a packet with a stalled output
    out_ready[0] = 1'b0;
    send(0, 8'h70, 8'd0, 1'b1, 1'b0, 1'b1);
    check("pre_reset_valid", 32'(out_valid[0]), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(out_valid[0]), 32'(0));
    check("async_reset_ready", 32'(in_ready[0]), 32'(0));
    exp_q0.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready[0] = 1'b1;
    send(0, 8'h71, 8'd0, 1'b1, 1'b1, 1'b1);
    check("post_reset_valid", 32'(out_valid[0]), 32'(1));
    repeat (5) @(posedge clk);
    #1;

    check("q0_drained", 32'(exp_q0.size()), 32'(0));
    check("q1_drained", 32'(exp_q1.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
